// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue sequencer: holds ALU operands stable for the opcode's
// latency, captures the answer with its destination tag, then offers it to writeback.
module alu_issue_ctrl #(
  parameter int LAT_SIMPLE = 2,
  parameter int LAT_MUL    = 4,
  parameter int LAT_DIV    = 36
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  input  logic [4:0]  in_opcode,
  input  logic [4:0]  in_rd,
  output logic [31:0] alu_operator_1,
  output logic [31:0] alu_operator_2,
  output logic [4:0]  alu_opcode,
  input  logic [31:0] alu_answer,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        busy
);

  localparam int LAT_MAX_SM = (LAT_SIMPLE > LAT_MUL) ? LAT_SIMPLE : LAT_MUL;
  localparam int LAT_MAX    = (LAT_MAX_SM > LAT_DIV) ? LAT_MAX_SM : LAT_DIV;
  localparam int CW         = $clog2(LAT_MAX) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] lat_m1;
  logic [4:0]    rd_reg;
  logic          accept, capture, release_res;

  // Latency class is chosen from the incoming opcode, not the registered one.
  always_comb begin
    lat_m1 = CW'(LAT_SIMPLE - 1);
    if (in_opcode >= 5'd2 && in_opcode <= 5'd5)
      lat_m1 = CW'(LAT_MUL - 1);
    else if (in_opcode >= 5'd6 && in_opcode <= 5'd9)
      lat_m1 = CW'(LAT_DIV - 1);
  end

  assign in_ready    = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign accept      = (state_reg == IDLE) && in_valid && !flush;
  assign capture     = (state_reg == WAIT) && (cnt_reg == '0) && !flush;
  assign release_res = (state_reg == DONE) && out_ready && !flush;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          state_next = WAIT;
          cnt_next   = lat_m1;
        end
        WAIT: if (cnt_reg == '0) state_next = DONE;
              else cnt_next = cnt_reg - 1'b1;
        DONE: if (out_ready) state_next = IDLE;
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Datapath registers survive flush; only the handshake state is aborted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_operator_1 <= '0;
      alu_operator_2 <= '0;
      alu_opcode     <= '0;
      rd_reg         <= '0;
      out_result     <= '0;
      out_rd         <= '0;
      out_valid      <= 1'b0;
    end else begin
      if (accept) begin
        alu_operator_1 <= in_op1;
        alu_operator_2 <= in_op2;
        alu_opcode     <= in_opcode;
        rd_reg         <= in_rd;
      end
      if (capture) begin
        out_result <= alu_answer;
        out_rd     <= rd_reg;
      end
      if (flush || release_res)
        out_valid <= 1'b0;
      else if (capture)
        out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU model, table of ops
// driven through a scoreboard, plus stall, flush and mid-op reset sequences.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic [4:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] alu_operator_1;
  logic [31:0] alu_operator_2;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_answer;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  opc;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    int          lat;
  } vec_t;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_opcode(in_opcode), .in_rd(in_rd),
    .alu_operator_1(alu_operator_1), .alu_operator_2(alu_operator_2),
    .alu_opcode(alu_opcode), .alu_answer(alu_answer),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU fed by the DUT's registered operand lines.
  always_comb begin
    case (alu_opcode)
      5'd0:                    alu_answer = alu_operator_1 + alu_operator_2;
      5'd1:                    alu_answer = alu_operator_1 - alu_operator_2;
      5'd2, 5'd3, 5'd4, 5'd5:  alu_answer = alu_operator_1 * alu_operator_2;
      5'd6, 5'd8:              alu_answer = (alu_operator_2 == 0) ? '1 : alu_operator_1 / alu_operator_2;
      5'd7, 5'd9:              alu_answer = (alu_operator_2 == 0) ? alu_operator_1 : alu_operator_1 % alu_operator_2;
      default:                 alu_answer = alu_operator_1 ^ alu_operator_2;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the posedge that retires the op.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] opc,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int lat,
                       input int stall);
    int   k;
    logic saw_ready;
    exp_t e;
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    in_op1    = a;
    in_op2    = b;
    in_opcode = opc;
    in_rd     = rd;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back('{exp_res, rd});
    check("alu_operator_1", alu_operator_1, a);
    check("alu_opcode", {27'd0, alu_opcode}, {27'd0, opc});
    k = 0;
    saw_ready = 1'b0;
    while (!out_valid && k < 100) begin
      if (in_ready) saw_ready = 1'b1;
      @(posedge clk);
      #1;
      k++;
    end
    check("in_ready_low_while_busy", {31'd0, saw_ready}, 32'd0);
    if (!out_valid) begin
      check("out_valid_timeout", 32'd0, 32'd1);
      sb.delete();
    end else begin
      e = sb.pop_front();
      check("latency", k, lat);
      check("out_result", out_result, e.res);
      check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
      for (int s = 0; s < stall; s++) begin
        @(posedge clk);
        #1;
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        check("stall_out_result", out_result, e.res);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("out_valid_released", {31'd0, out_valid}, 32'd0);
      check("in_ready_after_release", {31'd0, in_ready}, 32'd1);
    end
  endtask

  vec_t vecs[8];
  int   seen;

  initial begin
    vecs[0] = '{32'd5,   32'd7,  5'd0,  5'd3,  32'd12,  2};
    vecs[1] = '{32'd6,   32'd7,  5'd2,  5'd4,  32'd42,  4};
    vecs[2] = '{32'd10,  32'd3,  5'd1,  5'd6,  32'd7,   2};
    vecs[3] = '{32'd9,   32'd9,  5'd5,  5'd7,  32'd81,  4};
    vecs[4] = '{32'd100, 32'd7,  5'd9,  5'd8,  32'd2,   36};
    vecs[5] = '{32'd12,  32'd10, 5'd10, 5'd9,  32'd6,   2};
    vecs[6] = '{32'd15,  32'd5,  5'd31, 5'd31, 32'd10,  2};
    vecs[7] = '{32'd77,  32'd11, 5'd8,  5'd1,  32'd7,   36};

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_alu_opcode", {27'd0, alu_opcode}, 32'd0);
    check("rst_out_result", out_result, 32'd0);

    foreach (vecs[i])
      issue(vecs[i].op1, vecs[i].op2, vecs[i].opc, vecs[i].rd, vecs[i].exp_res, vecs[i].lat, 0);

    // Divide with writeback stalled 5 cycles
    issue(32'd100, 32'd7, 5'd6, 5'd12, 32'd14, 36, 5);

    // Flush on the 10th cycle of a divide
    in_valid = 1'b1; in_op1 = 32'd200; in_op2 = 32'd3; in_opcode = 5'd6; in_rd = 5'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_keeps_alu_opcode", {27'd0, alu_opcode}, 32'd6);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("flush_no_out_valid", seen, 0);

    // Flush in IDLE blocks the accept
    in_valid = 1'b1; in_op1 = 32'd4; in_op2 = 32'd4; in_opcode = 5'd0; in_rd = 5'd1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_idle_not_accepted", {31'd0, in_ready}, 32'd1);
    check("flush_idle_alu_op1", alu_operator_1, 32'd200);
    issue(32'd1, 32'd1, 5'd0, 5'd5, 32'd2, 2, 0);

    // Asynchronous reset in the middle of a multiply
    in_valid = 1'b1; in_op1 = 32'd8; in_op2 = 32'd8; in_opcode = 5'd3; in_rd = 5'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_alu_operator_1", alu_operator_1, 32'd0);
    check("arst_alu_opcode", {27'd0, alu_opcode}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(32'd3, 32'd3, 5'd2, 5'd10, 32'd9, 4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
